sdram_rw_arbiter_n: RTL and testbench
=====================================

Name: sdram_rw_arbiter_n

Overview:
- Parametrised N-port session arbiter that multiplexes one SDRAM read/write command interface among NUM_PORTS clients (display refresh, shift/draw, draw adapter, etc.).
- Grants whole sessions with round-robin fairness, not a fixed rotation of all ports.
- Adds a per-session watchdog so a hung client cannot starve the others.
- Sits between client adapters and the SDRAM controller glue.

Parameters:
NUM_PORTS, 4, number of client ports (2..8)
AW, 24, SDRAM word address width
DW, 16, data width
TIMEOUT, 4096, max cycles in OWN without an iCmd_Done or session end before abort (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  FSM advance enable
iSess_Req  in  NUM_PORTS  per-port session request (level)
oSess_Ack  out  NUM_PORTS  one-cycle grant pulse
iSess_Done  in  NUM_PORTS  per-port session-finished pulse
iP_Req  in  NUM_PORTS  per-port command request (level, held until done)
iP_We  in  NUM_PORTS  1=write, 0=read
iP_Addr  in  NUM_PORTS*AW  packed addresses, port k at [k*AW +: AW]
iP_WData  in  NUM_PORTS*DW  packed write data
oP_Done  out  NUM_PORTS  per-port command completion
oP_RData  out  NUM_PORTS*DW  packed read data, zero for non-owners
oCmd_Req  out  1  command request to SDRAM glue
oCmd_We  out  1  write flag
oCmd_Addr  out  AW  address
oCmd_WData  out  DW  write data
iCmd_Done  in  1  command completion pulse
iCmd_RData  in  DW  read data, valid with iCmd_Done
oOwner  out  clog2(NUM_PORTS)  current/last owner index
oBusy  out  1  high in ACK, OWN, RELEASE
oTimeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async): state IDLE; owner=0; last=NUM_PORTS-1 so port 0 wins first; watchdog=0. oSess_Ack=0 and oTimeout=0 (registered). All mux outputs 0 because the state is not ACK/OWN.
- FSM (registered, advances only when en=1; en=0 freezes state, counter and pulses — a pulse already high drops after one cycle regardless):
  - IDLE:
    - If any iSess_Req bit is set, the winner is the first requesting index searching last+1, last+2, … modulo NUM_PORTS.
    - Latch owner=winner. Go to ACK; oSess_Ack[winner]=1 during the ACK cycle.
    - With no requests, stay in IDLE.
  - ACK: one cycle. Clear oSess_Ack and watchdog. Go to OWN.
  - OWN:
    - iSess_Done[owner]=1 → RELEASE.
    - Otherwise, if watchdog==TIMEOUT-1 → oTimeout=1 for one cycle, then RELEASE.
    - Watchdog clears on iCmd_Done, otherwise increments. It saturates and never wraps.
  - RELEASE: one cycle. last=owner. Go to IDLE.
- Grant latency: request sampled in IDLE at cycle t → ack visible at t+1 → OWN at t+2. Minimum back-to-back session gap is 1 RELEASE cycle plus 1 IDLE cycle.
- Mux (combinational from registered owner and state), active only in ACK and OWN:
  - oCmd_Req = iP_Req[owner], oCmd_We = iP_We[owner]; address and write data are sliced at owner.
  - oP_Done[owner] = iCmd_Done; oP_RData[owner] = iCmd_RData.
  - All other oP_Done and oP_RData slices are 0.
  - In IDLE and RELEASE, every mux output is 0. oCmd_Req deasserts in RELEASE even if a command is pending; the controller must tolerate the abort.
- Non-owner iSess_Req, iSess_Done, iP_Req are ignored. iSess_Done from the owner in ACK is ignored.
- A requester that drops iSess_Req before winning loses nothing; it is simply not selected.
- The watchdog abort does not alter round-robin order; the aborted port becomes `last`.
- Simultaneous iSess_Done and timeout in the same cycle: the session ends normally and oTimeout stays 0.
- Reset mid-session: immediate return to IDLE and outputs 0; clients must restart.

Test Plan:
- Reset with all requests high → outputs 0; after release, oSess_Ack=0001 at first IDLE→ACK, oOwner=0.
- Port 2 alone: write addr 0x00ABCD data 0x1234 → oCmd_Req=1, oCmd_We=1, oCmd_Addr=0x00ABCD; iCmd_Done → oP_Done=0100; iSess_Done[2] → IDLE after 1 RELEASE cycle.
- All 4 ports request continuously, each session ends after one read → grant order 0,1,2,3,0; read data 0xBEEF appears only on port owner slice.
- TIMEOUT=16, owner 1 never completes → oTimeout pulses after 16 OWN cycles, oCmd_Req drops, next grant goes to port 2.
- en=0 in OWN for 10 cycles → state held, mux stays live, watchdog frozen; iSess_Done ignored until en=1.
- iSess_Done and timeout coincident → oTimeout=0, normal release; async reset mid-OWN → oCmd_Req=0 same cycle.

Source files
------------

// File: rtl/sdram_rw_arbiter_n.sv
// Session arbiter sharing one SDRAM command port among NUM_PORTS clients.
// Grants whole sessions round-robin; a per-session watchdog aborts hung owners.
module sdram_rw_arbiter_n #(
   parameter int NUM_PORTS = 4,
   parameter int AW        = 24,
   parameter int DW        = 16,
   parameter int TIMEOUT   = 4096,
   localparam int OW       = $clog2(NUM_PORTS),
   localparam int WW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [NUM_PORTS-1:0]    iSess_Req,
   output logic [NUM_PORTS-1:0]    oSess_Ack,
   input  logic [NUM_PORTS-1:0]    iSess_Done,
   input  logic [NUM_PORTS-1:0]    iP_Req,
   input  logic [NUM_PORTS-1:0]    iP_We,
   input  logic [NUM_PORTS*AW-1:0] iP_Addr,
   input  logic [NUM_PORTS*DW-1:0] iP_WData,
   output logic [NUM_PORTS-1:0]    oP_Done,
   output logic [NUM_PORTS*DW-1:0] oP_RData,
   output logic                    oCmd_Req,
   output logic                    oCmd_We,
   output logic [AW-1:0]           oCmd_Addr,
   output logic [DW-1:0]           oCmd_WData,
   input  logic                    iCmd_Done,
   input  logic [DW-1:0]           iCmd_RData,
   output logic [OW-1:0]           oOwner,
   output logic                    oBusy,
   output logic                    oTimeout
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_OWN, ST_RELEASE} state_t;

   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [OW-1:0]          last_q, last_d;
   logic [WW-1:0]          wdog_q, wdog_d;
   logic [NUM_PORTS-1:0]   ack_q, ack_d;
   logic                   tmo_q, tmo_d;
   logic                   win_found;
   logic [OW-1:0]          win_idx;
   logic                   mux_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= OW'(NUM_PORTS - 1);
         wdog_q  <= '0;
         ack_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         ack_q   <= ack_d;
         tmo_q   <= tmo_d;
      end
   end

   // Round-robin search starting just after the last owner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         if (!win_found && iSess_Req[(int'(last_q) + i) % NUM_PORTS]) begin
            win_found = 1'b1;
            win_idx   = OW'((int'(last_q) + i) % NUM_PORTS);
         end
      end
   end

   // Pulses default low, so they last one cycle even while en freezes the FSM.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      ack_d   = '0;
      tmo_d   = 1'b0;
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (win_found) begin
                  state_d = ST_ACK;
                  owner_d = win_idx;
                  ack_d   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
               end
            end
            ST_ACK: begin
               wdog_d  = '0;
               state_d = ST_OWN;
            end
            ST_OWN: begin
               if (iCmd_Done) begin
                  wdog_d = '0;
               end else if (wdog_q != WDOG_LAST) begin
                  wdog_d = wdog_q + 1'b1;
               end
               // A normal end takes priority over a coincident watchdog expiry.
               if (iSess_Done[owner_q]) begin
                  state_d = ST_RELEASE;
               end else if (wdog_q == WDOG_LAST) begin
                  tmo_d   = 1'b1;
                  state_d = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               last_d  = owner_q;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign mux_active = (state_q == ST_ACK) || (state_q == ST_OWN);

   assign oCmd_Req   = mux_active & iP_Req[owner_q];
   assign oCmd_We    = mux_active & iP_We[owner_q];
   assign oCmd_Addr  = mux_active ? iP_Addr[int'(owner_q)*AW +: AW]  : '0;
   assign oCmd_WData = mux_active ? iP_WData[int'(owner_q)*DW +: DW] : '0;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic sel;
      assign sel                     = mux_active && (owner_q == OW'(gi));
      assign oP_Done[gi]             = sel & iCmd_Done;
      assign oP_RData[gi*DW +: DW]   = sel ? iCmd_RData : '0;
   end

   assign oSess_Ack = ack_q;
   assign oTimeout  = tmo_q;
   assign oOwner    = owner_q;
   assign oBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_rw_arbiter_n.sv
// Scoreboarded bench for sdram_rw_arbiter_n: expected grants are queued as
// requests are raised and compared whenever the arbiter pulses oSess_Ack.
module tb_sdram_rw_arbiter_n;

   localparam int NP = 4;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int TO = 16;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic [NP-1:0]   iSess_Req;
   logic [NP-1:0]   oSess_Ack;
   logic [NP-1:0]   iSess_Done;
   logic [NP-1:0]   iP_Req;
   logic [NP-1:0]   iP_We;
   logic [NP*AW-1:0] iP_Addr;
   logic [NP*DW-1:0] iP_WData;
   logic [NP-1:0]   oP_Done;
   logic [NP*DW-1:0] oP_RData;
   logic            oCmd_Req;
   logic            oCmd_We;
   logic [AW-1:0]   oCmd_Addr;
   logic [DW-1:0]   oCmd_WData;
   logic            iCmd_Done;
   logic [DW-1:0]   iCmd_RData;
   logic [1:0]      oOwner;
   logic            oBusy;
   logic            oTimeout;

   int n_checks = 0;
   int n_errors = 0;
   int exp_grant_q[$];

   sdram_rw_arbiter_n #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .iSess_Req(iSess_Req), .oSess_Ack(oSess_Ack), .iSess_Done(iSess_Done),
      .iP_Req(iP_Req), .iP_We(iP_We), .iP_Addr(iP_Addr), .iP_WData(iP_WData),
      .oP_Done(oP_Done), .oP_RData(oP_RData),
      .oCmd_Req(oCmd_Req), .oCmd_We(oCmd_We), .oCmd_Addr(oCmd_Addr),
      .oCmd_WData(oCmd_WData), .iCmd_Done(iCmd_Done), .iCmd_RData(iCmd_RData),
      .oOwner(oOwner), .oBusy(oBusy), .oTimeout(oTimeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int bound);
      for (int i = 0; i < bound; i++) begin
         tick();
         if (oSess_Ack != '0) return;
      end
      check("ack_wait_expired", 64'd0, 64'd1);
   endtask

   // Grant scoreboard: every ack pulse must match the oldest queued grant.
   always @(negedge clk) begin
      if (oSess_Ack != '0) begin
         if (exp_grant_q.size() == 0) begin
            check("ack_unexpected", 64'(oSess_Ack), 64'd0);
         end else begin
            int e;
            e = exp_grant_q.pop_front();
            check("ack_vec", 64'(oSess_Ack), 64'd1 << e);
            check("ack_owner", 64'(oOwner), 64'(e));
         end
      end
   end

   initial begin
      int n;
      rst_n      = 1'b0;
      en         = 1'b1;
      iSess_Req  = 4'hF;
      iSess_Done = '0;
      iP_Req     = 4'hF;
      iP_We      = '0;
      iP_Addr    = {24'h333333, 24'h00ABCD, 24'h111111, 24'h000000};
      iP_WData   = {16'h3333, 16'h1234, 16'h1111, 16'h0000};
      iCmd_Done  = 1'b0;
      iCmd_RData = '0;

      // Reset with all requests high: every output quiet.
      tick(); tick();
      check("rst_ack", 64'(oSess_Ack), 64'd0);
      check("rst_cmd_req", 64'(oCmd_Req), 64'd0);
      check("rst_busy", 64'(oBusy), 64'd0);
      check("rst_owner", 64'(oOwner), 64'd0);
      check("rst_timeout", 64'(oTimeout), 64'd0);
      exp_grant_q.push_back(0);
      rst_n = 1'b1;
      wait_ack(4);
      check("t1_cmd_req_in_ack", 64'(oCmd_Req), 64'd1);
      check("t1_busy", 64'(oBusy), 64'd1);
      iSess_Req = '0;
      iP_Req    = '0;
      tick();
      iSess_Done = 4'b0001;
      tick();
      iSess_Done = '0;
      check("t1_release_cmd_req", 64'(oCmd_Req), 64'd0);
      check("t1_release_busy", 64'(oBusy), 64'd1);
      tick();
      check("t1_idle_busy", 64'(oBusy), 64'd0);

      // Port 2 alone performs a write.
      exp_grant_q.push_back(2);
      iSess_Req = 4'b0100;
      wait_ack(4);
      iSess_Req = '0;
      iP_Req    = 4'b0100;
      iP_We     = 4'b0100;
      tick();
      check("t2_cmd_req", 64'(oCmd_Req), 64'd1);
      check("t2_cmd_we", 64'(oCmd_We), 64'd1);
      check("t2_cmd_addr", 64'(oCmd_Addr), 64'h00ABCD);
      check("t2_cmd_wdata", 64'(oCmd_WData), 64'h1234);
      iSess_Done = 4'b1011;
      tick();
      iSess_Done = '0;
      check("t2_nonowner_done_ignored", 64'(oBusy), 64'd1);
      iCmd_Done = 1'b1;
      #1;
      check("t2_p_done", 64'(oP_Done), 64'b0100);
      tick();
      iCmd_Done  = 1'b0;
      iP_Req     = '0;
      iP_We      = '0;
      iSess_Done = 4'b0100;
      tick();
      iSess_Done = '0;
      check("t2_release_owner", 64'(oOwner), 64'd2);
      check("t2_release_busy", 64'(oBusy), 64'd1);
      tick();
      check("t2_idle_busy", 64'(oBusy), 64'd0);

      // Fresh reset, then all four ports contend with one read per session.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(1);
      exp_grant_q.push_back(2);
      exp_grant_q.push_back(3);
      exp_grant_q.push_back(0);
      iSess_Req = 4'hF;
      wait_ack(4);
      for (int s = 0; s < 5; s++) begin
         int k;
         k = s % NP;
         if (s == 4) iSess_Req = '0;
         tick();
         iP_Req     = 4'(1 << k);
         iCmd_RData = 16'hBEEF;
         iCmd_Done  = 1'b1;
         #1;
         check($sformatf("t3_rdata_s%0d", s), 64'(oP_RData), 64'(64'h0000_0000_0000_BEEF << (k*DW)));
         check($sformatf("t3_pdone_s%0d", s), 64'(oP_Done), 64'd1 << k);
         tick();
         iCmd_Done  = 1'b0;
         iCmd_RData = '0;
         iP_Req     = '0;
         iSess_Done = 4'(1 << k);
         tick();
         iSess_Done = '0;
         if (s < 4) wait_ack(4);
      end
      tick();

      // Watchdog abort on port 1; ports 0 and 2 waiting, 2 must be next.
      exp_grant_q.push_back(1);
      iSess_Req = 4'b0010;
      wait_ack(4);
      iSess_Req = 4'b0101;
      iP_Req    = 4'b0010;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (oTimeout) break;
         n++;
      end
      check("t4_own_cycles_to_timeout", 64'(n), 64'd16);
      check("t4_cmd_req_dropped", 64'(oCmd_Req), 64'd0);
      iP_Req = '0;
      exp_grant_q.push_back(2);
      tick();
      check("t4_timeout_one_cycle", 64'(oTimeout), 64'd0);
      wait_ack(4);
      iSess_Req = '0;

      // en=0 while owning: state, mux and watchdog held, iSess_Done ignored.
      iP_Req = 4'b0100;
      tick();
      repeat (5) tick();
      en         = 1'b0;
      iSess_Done = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("t5_frozen_busy_%0d", i), 64'(oBusy), 64'd1);
         check($sformatf("t5_frozen_cmd_req_%0d", i), 64'(oCmd_Req), 64'd1);
      end
      check("t5_frozen_owner", 64'(oOwner), 64'd2);
      iSess_Done = '0;
      en         = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (oTimeout) break;
         n++;
      end
      check("t5_remaining_own_cycles", 64'(n), 64'd10);
      iP_Req = '0;
      tick();

      // Session end coincident with watchdog expiry: no timeout pulse.
      exp_grant_q.push_back(3);
      iSess_Req = 4'b1000;
      wait_ack(4);
      iSess_Req = '0;
      tick();
      repeat (TO - 1) tick();
      iSess_Done = 4'b1000;
      tick();
      iSess_Done = '0;
      check("t6_coincident_timeout", 64'(oTimeout), 64'd0);
      check("t6_coincident_release", 64'(oBusy), 64'd1);
      tick();

      // Asynchronous reset in the middle of OWN.
      exp_grant_q.push_back(0);
      iSess_Req = 4'b0001;
      wait_ack(4);
      iSess_Req = '0;
      iP_Req    = 4'b0001;
      tick();
      check("t7_cmd_req_before_rst", 64'(oCmd_Req), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_cmd_req_async_rst", 64'(oCmd_Req), 64'd0);
      check("t7_busy_async_rst", 64'(oBusy), 64'd0);
      iP_Req = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("t7_idle_after_rst", 64'(oBusy), 64'd0);

      check("grants_outstanding", 64'(exp_grant_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
